// File: rtl/inventory_tracker.sv
// Per-stock signed position table: saturating fill updates, init sweep after reset/clear,
// |position| limit flags and a 2-stage read pipeline returning raw and normalised positions.
module inventory_tracker #(
    parameter int unsigned FP_WORD_SIZE = 64,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_STOCKS   = 8,
    localparam int unsigned SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_exec_valid,
    output logic                    o_exec_ready,
    input  logic [SID_W-1:0]        i_exec_stock_id,
    input  logic [DATA_WIDTH-1:0]   i_exec_qty,
    input  logic                    i_exec_side,
    input  logic [FP_WORD_SIZE-1:0] i_max_inventory_reciprocal,
    input  logic [DATA_WIDTH-2:0]   i_pos_limit,
    input  logic                    i_rd_en,
    input  logic [SID_W-1:0]        i_rd_stock_id,
    output logic                    o_rd_valid,
    output logic [DATA_WIDTH-1:0]   o_position,
    output logic [FP_WORD_SIZE-1:0] o_norm_inventory,
    output logic [NUM_STOCKS-1:0]   o_limit_flags,
    output logic                    o_sat_pulse
);
    // Two guard bits so a full-range unsigned qty cannot wrap before the clamp.
    localparam int unsigned SUM_W  = DATA_WIDTH + 2;
    localparam int unsigned PROD_W = DATA_WIDTH + FP_WORD_SIZE + 1;

    localparam logic [SUM_W-1:0] POS_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [SUM_W-1:0] POS_MIN = {3'b111, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic {StInit, StRun} state_e;

    state_e                r_state, w_state_next;
    logic [SID_W-1:0]      r_ptr, w_ptr_next;
    logic                  w_init_wr;
    logic [DATA_WIDTH-1:0] r_pos [NUM_STOCKS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StInit;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_init_wr    = 1'b0;
        if (i_reset || i_clear) begin
            w_state_next = StInit;
            w_ptr_next   = '0;
        end else if (r_state == StInit) begin
            w_init_wr = 1'b1;
            if (r_ptr == SID_W'(NUM_STOCKS - 1)) begin
                w_state_next = StRun;
            end else begin
                w_ptr_next = r_ptr + 1'b1;
            end
        end
    end

    logic                  w_accept, w_fill_id_ok, w_rd_id_ok, w_clamp;
    logic [DATA_WIDTH-1:0] w_cur, w_clamped;
    logic [SUM_W-1:0]      w_qty_ext, w_sum;

    assign o_exec_ready = (r_state == StRun) && !i_clear && !i_reset;
    assign w_accept     = i_exec_valid && o_exec_ready;
    assign w_fill_id_ok = 32'(i_exec_stock_id) < NUM_STOCKS;
    assign w_cur        = w_fill_id_ok ? r_pos[i_exec_stock_id] : '0;
    assign w_qty_ext    = {2'b00, i_exec_qty};
    assign w_sum        = {{2{w_cur[DATA_WIDTH-1]}}, w_cur}
                        + (i_exec_side ? (~w_qty_ext + 1'b1) : w_qty_ext);

    always_comb begin
        w_clamp   = 1'b0;
        w_clamped = w_sum[DATA_WIDTH-1:0];
        if ($signed(w_sum) > $signed(POS_MAX)) begin
            w_clamp   = 1'b1;
            w_clamped = POS_MAX[DATA_WIDTH-1:0];
        end else if ($signed(w_sum) < $signed(POS_MIN)) begin
            w_clamp   = 1'b1;
            w_clamped = POS_MIN[DATA_WIDTH-1:0];
        end
    end

    // Single write port shared by the init sweep and accepted fills (never both at once).
    logic                  w_wr_en;
    logic [SID_W-1:0]      w_wr_id;
    logic [DATA_WIDTH-1:0] w_wr_data;

    assign w_wr_en   = w_init_wr || (w_accept && w_fill_id_ok);
    assign w_wr_id   = w_init_wr ? r_ptr : i_exec_stock_id;
    assign w_wr_data = w_init_wr ? '0 : w_clamped;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_pos[w_wr_id] <= w_wr_data;
        end
    end

    logic r_sat;
    always_ff @(posedge i_clk) begin
        if (i_reset) r_sat <= 1'b0;
        else         r_sat <= w_accept && w_fill_id_ok && w_clamp;
    end
    assign o_sat_pulse = r_sat;

    function automatic logic [DATA_WIDTH-1:0] abs_pos(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Entries not yet swept by the init pointer report no alarm.
    logic [NUM_STOCKS-1:0] w_flags, r_flags;
    always_comb begin
        w_flags = '0;
        for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
            if (!(r_state == StInit && i >= 32'(r_ptr))) begin
                w_flags[i] = abs_pos(r_pos[i]) >= {1'b0, i_pos_limit};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_flags <= '0;
        else         r_flags <= w_flags;
    end
    assign o_limit_flags = r_flags;

    logic                  r_s0_valid;
    logic [DATA_WIDTH-1:0] r_s0_pos, w_rd_pos;

    assign w_rd_id_ok = 32'(i_rd_stock_id) < NUM_STOCKS;

    always_comb begin
        w_rd_pos = '0;
        if (w_rd_id_ok) begin
            if (w_wr_en && (w_wr_id == i_rd_stock_id)) w_rd_pos = w_wr_data;
            else                                       w_rd_pos = r_pos[i_rd_stock_id];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_s0_valid <= 1'b0;
        else         r_s0_valid <= i_rd_en;
        r_s0_pos <= w_rd_pos;
    end

    logic [PROD_W-1:0]        w_prod;
    logic [DATA_WIDTH+1:0]    w_prod_hi;
    logic [FP_WORD_SIZE-1:0]  w_norm;

    // Integer times Q.FRAC reciprocal is already in Q.FRAC; only the range needs clamping.
    assign w_prod = $signed({{(FP_WORD_SIZE+1){r_s0_pos[DATA_WIDTH-1]}}, r_s0_pos})
                  * $signed({{(DATA_WIDTH+1){1'b0}}, i_max_inventory_reciprocal});
    assign w_prod_hi = w_prod[PROD_W-1:FP_WORD_SIZE-1];
    assign w_norm = (&w_prod_hi || !(|w_prod_hi)) ? w_prod[FP_WORD_SIZE-1:0]
                  : (w_prod[PROD_W-1] ? {1'b1, {(FP_WORD_SIZE-1){1'b0}}}
                                      : {1'b0, {(FP_WORD_SIZE-1){1'b1}}});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_valid       <= 1'b0;
            o_position       <= '0;
            o_norm_inventory <= '0;
        end else begin
            o_rd_valid <= r_s0_valid;
            if (r_s0_valid) begin
                o_position       <= r_s0_pos;
                o_norm_inventory <= w_norm;
            end
        end
    end

endmodule

// File: tb/tb_inventory_tracker.sv
// Randomised and directed bench for inventory_tracker against a cycle-level behavioural model
// built from integer arithmetic on a per-stock position array.
module tb_inventory_tracker;
    localparam int FPW = 64;
    localparam int DW  = 32;
    localparam int NS  = 8;
    localparam int SW  = 3;

    logic           clk = 1'b0;
    logic           i_reset = 1'b1, i_clear = 1'b0, i_exec_valid = 1'b0, i_exec_side = 1'b0;
    logic           i_rd_en = 1'b0;
    logic [SW-1:0]  i_exec_stock_id = '0, i_rd_stock_id = '0;
    logic [DW-1:0]  i_exec_qty = '0;
    logic [FPW-1:0] i_recip = '0;
    logic [DW-2:0]  i_pos_limit = '0;
    logic           o_exec_ready, o_rd_valid, o_sat_pulse;
    logic [DW-1:0]  o_position;
    logic [FPW-1:0] o_norm_inventory;
    logic [NS-1:0]  o_limit_flags;

    always #5 clk = ~clk;

    inventory_tracker #(.FP_WORD_SIZE(FPW), .DATA_WIDTH(DW), .NUM_STOCKS(NS)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear),
        .i_exec_valid(i_exec_valid), .o_exec_ready(o_exec_ready),
        .i_exec_stock_id(i_exec_stock_id), .i_exec_qty(i_exec_qty), .i_exec_side(i_exec_side),
        .i_max_inventory_reciprocal(i_recip), .i_pos_limit(i_pos_limit),
        .i_rd_en(i_rd_en), .i_rd_stock_id(i_rd_stock_id), .o_rd_valid(o_rd_valid),
        .o_position(o_position), .o_norm_inventory(o_norm_inventory),
        .o_limit_flags(o_limit_flags), .o_sat_pulse(o_sat_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    longint     m_pos [NS];
    bit         m_known [NS];
    bit         m_run = 1'b0;
    int         m_ptr = 0;
    logic [7:0] m_flags = '0;
    bit         m_sat = 1'b0;
    bit         m_s0_valid = 1'b0, m_s0_known = 1'b0;
    longint     m_s0_pos = 0;
    bit         m_out_valid = 1'b0, m_out_known = 1'b1;
    longint     m_out_pos = 0;
    logic [63:0] m_out_norm = '0;

    localparam longint PMAX = 64'sd2147483647;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [63:0] norm_of(input longint pos, input logic [63:0] recip);
        logic signed [127:0] p, b, hi, lo;
        p  = pos;
        b  = $signed({64'd0, recip});
        p  = p * b;
        hi = 128'sh7FFF_FFFF_FFFF_FFFF;
        lo = -hi - 1;
        if (p > hi) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (p < lo) return 64'h8000_0000_0000_0000;
        return p[63:0];
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        logic [7:0] nflags;
        bit         acc, wr, sat;
        int         wid;
        longint     wdata, sum, cl;
        for (int i = 0; i < NS; i++)
            nflags[i] = (!m_run && i >= m_ptr) ? 1'b0 : (absl(m_pos[i]) >= longint'(i_pos_limit));
        acc = i_exec_valid && m_run && !i_clear && !i_reset;
        wr = 1'b0; sat = 1'b0; wid = 0; wdata = 0;
        if (!i_reset && !i_clear && !m_run) begin
            wr = 1'b1; wid = m_ptr; wdata = 0;
        end else if (acc) begin
            sum = m_pos[i_exec_stock_id] + (i_exec_side ? -longint'(i_exec_qty)
                                                         : longint'(i_exec_qty));
            cl  = (sum > PMAX) ? PMAX : ((sum < -PMAX) ? -PMAX : sum);
            sat = (cl != sum);
            wr = 1'b1; wid = int'(i_exec_stock_id); wdata = cl;
        end
        if (i_reset) begin
            m_out_valid = 1'b0; m_out_pos = 0; m_out_norm = '0; m_out_known = 1'b1;
        end else begin
            m_out_valid = m_s0_valid;
            if (m_s0_valid) begin
                m_out_pos   = m_s0_pos;
                m_out_known = m_s0_known;
                m_out_norm  = norm_of(m_s0_pos, i_recip);
            end
        end
        if (wr) begin
            m_pos[wid]   = wdata;
            m_known[wid] = 1'b1;
        end
        m_s0_valid = i_rd_en && !i_reset;
        m_s0_pos   = m_pos[i_rd_stock_id];
        m_s0_known = m_known[i_rd_stock_id];
        m_flags    = i_reset ? 8'h00 : nflags;
        m_sat      = i_reset ? 1'b0 : sat;
        if (i_reset || i_clear) begin
            m_run = 1'b0; m_ptr = 0;
        end else if (!m_run) begin
            if (m_ptr == NS - 1) m_run = 1'b1;
            else                 m_ptr++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!i_reset && !i_clear) chk("ready", 64'(o_exec_ready), 64'(m_run));
            chk("rd_valid", 64'(o_rd_valid), 64'(m_out_valid));
            if (m_out_known) begin
                chk("position", 64'(o_position), 64'(m_out_pos[31:0]));
                chk("norm", o_norm_inventory, m_out_norm);
            end
            chk("flags", 64'(o_limit_flags), 64'(m_flags));
            chk("sat", 64'(o_sat_pulse), 64'(m_sat));
        end
    end

    task automatic fill(input int id, input logic [31:0] qty, input bit side);
        i_exec_valid = 1'b1; i_exec_stock_id = SW'(id); i_exec_qty = qty; i_exec_side = side;
        tick();
        i_exec_valid = 1'b0;
    endtask

    task automatic do_read(input int id, output logic [31:0] p, output logic [63:0] n);
        i_rd_en = 1'b1; i_rd_stock_id = SW'(id);
        tick();
        i_rd_en = 1'b0;
        tick();
        @(negedge clk);
        chk("rd_latency", 64'(o_rd_valid), 64'd1);
        p = o_position;
        n = o_norm_inventory;
    endtask

    task automatic count_ready_low(output int cnt);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            if (o_exec_ready) break;
            cnt++;
            tick();
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] p;
        logic [63:0] n;
        int          cnt;
        int          sums [4];
        int          r;
        sums = '{1, 3, 6, 10};
        for (int i = 0; i < NS; i++) begin
            m_pos[i] = 0; m_known[i] = 1'b0;
        end

        // Reset, then the init sweep keeps ready low for NUM_STOCKS cycles.
        tick();
        chk_en = 1'b1;
        repeat (9) tick();
        i_reset = 1'b0;
        count_ready_low(cnt);
        chk("ready_low_after_reset", 64'(cnt), 64'd8);
        for (int id = 0; id < NS; id++) begin
            do_read(id, p, n);
            chk("reset_read_pos", 64'(p), 64'd0);
        end

        // Buy 64 at 1/256 -> 0.25.
        i_recip = 64'h0000_0000_0100_0000;
        fill(2, 32'd64, 1'b0);
        do_read(2, p, n);
        chk("buy64_pos", 64'(p), 64'd64);
        chk("buy64_norm", n, 64'h0000_0000_4000_0000);

        // Fill and read of the same id in one cycle: read sees the fill.
        fill(1, 32'd5, 1'b0);
        i_exec_valid = 1'b1; i_exec_stock_id = 3'd1; i_exec_qty = 32'd10; i_exec_side = 1'b1;
        i_rd_en = 1'b1; i_rd_stock_id = 3'd1;
        tick();
        i_exec_valid = 1'b0; i_rd_en = 1'b0;
        tick();
        @(negedge clk);
        chk("bypass_pos", 64'(o_position), 64'h0000_0000_FFFF_FFFB);
        chk("bypass_norm", o_norm_inventory, 64'hFFFF_FFFF_FB00_0000);

        // Back-to-back fills with interleaved reads.
        for (int j = 1; j <= 6; j++) begin
            if (j <= 4) begin
                i_exec_valid = 1'b1; i_exec_stock_id = 3'd3; i_exec_qty = 32'(j);
                i_exec_side = 1'b0; i_rd_en = 1'b1; i_rd_stock_id = 3'd3;
            end else begin
                i_exec_valid = 1'b0; i_rd_en = 1'b0;
            end
            tick();
            @(negedge clk);
            if (j >= 2 && j <= 5) chk("b2b_sum", 64'(o_position), 64'(sums[j-2]));
        end

        // Positive and negative saturation.
        fill(4, 32'h7FFF_FFF0, 1'b0);
        fill(4, 32'h0000_0100, 1'b0);
        @(negedge clk);
        chk("sat_pulse_hi", 64'(o_sat_pulse), 64'd1);
        tick();
        @(negedge clk);
        chk("sat_pulse_lo", 64'(o_sat_pulse), 64'd0);
        i_recip = 64'hFFFF_FFFF_FFFF_FFFF;
        do_read(4, p, n);
        chk("sat_pos_max", 64'(p), 64'h0000_0000_7FFF_FFFF);
        chk("sat_norm_max", n, 64'h7FFF_FFFF_FFFF_FFFF);
        fill(5, 32'hFFFF_FFFF, 1'b1);
        do_read(5, p, n);
        chk("sat_pos_min", 64'(p), 64'h0000_0000_8000_0001);
        chk("sat_norm_min", n, 64'h8000_0000_0000_0000);

        // Limit flag, then runtime clear with a fill in the same cycle.
        i_pos_limit = 31'd100;
        fill(0, 32'd99, 1'b0);
        tick();
        @(negedge clk);
        chk("flag_below", 64'(o_limit_flags[0]), 64'd0);
        fill(0, 32'd1, 1'b0);
        @(negedge clk);
        chk("flag_lag", 64'(o_limit_flags[0]), 64'd0);
        tick();
        @(negedge clk);
        chk("flag_rise", 64'(o_limit_flags[0]), 64'd1);
        i_clear = 1'b1; i_exec_valid = 1'b1; i_exec_stock_id = 3'd1; i_exec_qty = 32'd7;
        tick();
        i_clear = 1'b0; i_exec_valid = 1'b0;
        count_ready_low(cnt);
        chk("ready_low_after_clear", 64'(cnt), 64'd8);
        chk("flags_after_clear", 64'(o_limit_flags), 64'd0);
        do_read(0, p, n);
        chk("clear_pos0", 64'(p), 64'd0);
        do_read(4, p, n);
        chk("clear_pos4", 64'(p), 64'd0);

        // Randomised traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 999));
            i_reset = (r < 3);
            i_clear = (r >= 3 && r < 8);
            i_exec_valid = 1'($urandom_range(0, 1));
            i_exec_stock_id = SW'($urandom_range(0, NS - 1));
            i_exec_qty = ($urandom_range(0, 15) == 0) ? 32'($urandom)
                                                       : 32'($urandom_range(0, 3000));
            i_exec_side = 1'($urandom_range(0, 1));
            i_rd_en = ($urandom_range(0, 2) != 0);
            i_rd_stock_id = SW'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 2))
                    0: i_recip = 64'h0000_0000_0100_0000;
                    1: i_recip = 64'hFFFF_FFFF_FFFF_FFFF;
                    default: i_recip = {32'($urandom), 32'($urandom)};
                endcase
            end
            if ($urandom_range(0, 63) == 0)
                i_pos_limit = ($urandom_range(0, 3) == 0) ? 31'($urandom)
                                                          : 31'($urandom_range(1, 6000));
            tick();
        end
        i_reset = 1'b0; i_clear = 1'b0; i_exec_valid = 1'b0; i_rd_en = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
